// File: rtl/conv_window_sum_stream.sv
// Streaming KxK box-sum over a raster image: K-1 line buffers feed a KxK window, one sum per valid position.
// Latency: 1 cycle from the window's bottom-right pixel to out_valid.
// Backpressure: single output register; in_ready = !out_valid | out_ready.
module conv_window_sum_stream #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  localparam int OUT_W = (K == 1) ? DATA_W : DATA_W + $clog2(K * K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB = (K > 1) ? K - 1 : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] line_buf [LB][IMG_W];
  logic [DATA_W-1:0] win      [K][K];
  logic [DATA_W-1:0] win_nxt  [K][K];
  logic [DATA_W-1:0] col_new  [K];
  logic [OUT_W-1:0]  sum;
  logic              acc;
  logic              load;
  logic              col_end;
  logic              row_end;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign load     = acc && (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  // Row 0 of the window is the oldest line; the live pixel enters at the bottom.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col_new[r] = in_data;
    end
    for (int r = 0; r < K - 1; r++) begin
      col_new[r] = line_buf[r][col];
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][K-1] = col_new[r];
    end
    sum = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        sum = sum + OUT_W'(win_nxt[r][c]);
      end
    end
  end

  // Data path carries no reset: counters gate every observable output.
  always_ff @(posedge clk) begin
    if (acc) begin
      win <= win_nxt;
      for (int r = 0; r < K - 1; r++) begin
        line_buf[r][col] <= col_new[r+1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (acc) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (load) begin
        out_data  <= sum;
        out_valid <= 1'b1;
        out_last  <= row_end && col_end;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_sum_stream.sv
// Scoreboard bench: a 3x3/4x4 instance and a 1x1/2x2 instance, expected sums hand-computed.
module tb_conv_window_sum_stream;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_last;
  logic [15:0] a_in_data = '0;
  logic [19:0] a_out_data;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_last;
  logic [15:0] b_in_data = '0;
  logic [15:0] b_out_data;

  conv_window_sum_stream #(.DATA_W(16), .K(3), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  conv_window_sum_stream #(.DATA_W(16), .K(1), .IMG_W(2), .IMG_H(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  typedef struct packed {
    logic [19:0] d;
    logic        l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [19:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [19:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    qb.push_back(e);
  endtask

  // Monitor: every handshake pops one expected response.
  always @(negedge clk) begin
    if (reset && a_out_valid && a_out_ready) begin : mon_a
      exp_t e;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got %0h expected no output", a_out_data);
      end else begin
        e = qa.pop_front();
        chk("a_data", 32'(a_out_data), 32'(e.d));
        chk("a_last", 32'(a_out_last), 32'(e.l));
      end
    end
    if (reset && b_out_valid && b_out_ready) begin : mon_b
      exp_t e;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got %0h expected no output", b_out_data);
      end else begin
        e = qb.pop_front();
        chk("b_data", 32'(b_out_data), 32'(e.d));
        chk("b_last", 32'(b_out_last), 32'(e.l));
      end
    end
  end

  task automatic send_a(input logic [15:0] d);
    int n;
    logic rdy;
    a_in_valid = 1'b1;
    a_in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      rdy = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d);
    int n;
    logic rdy;
    b_in_valid = 1'b1;
    b_in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      rdy = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL b_accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    b_in_valid = 1'b0;
  endtask

  task automatic frame_a(input int base);
    for (int i = 0; i < 16; i++) send_a(16'(i + base));
  endtask

  task automatic push_t1(input int base);
    push_a(20'(45 + 9 * base), 1'b0);
    push_a(20'(54 + 9 * base), 1'b0);
    push_a(20'(81 + 9 * base), 1'b0);
    push_a(20'(90 + 9 * base), 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data",  32'(a_out_data),  32'd0);
    chk("rst_a_last",  32'(a_out_last),  32'd0);
    chk("rst_a_ready", 32'(a_in_ready),  32'd1);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // T1: pixels 0..15
    push_t1(0);
    frame_a(0);
    drain("t1_drain");

    // T2: stall for 5 cycles once the first sum appears
    push_t1(0);
    fork
      frame_a(0);
      begin : stall
        int n;
        n = 0;
        while (!a_out_valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("t2_first_valid", 32'(a_out_valid), 32'd1);
        a_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t2_hold_ready", 32'(a_in_ready),  32'd0);
          chk("t2_hold_valid", 32'(a_out_valid), 32'd1);
          chk("t2_hold_data",  32'(a_out_data),  32'd45);
          @(posedge clk);
          #1;
        end
        a_out_ready = 1'b1;
      end
    join
    drain("t2_drain");

    // T3: saturated pixels, 9*0xFFFF fits in 20 bits
    for (int i = 0; i < 4; i++) push_a(20'h8FFF7, i == 3);
    for (int i = 0; i < 16; i++) send_a(16'hFFFF);
    drain("t3_drain");

    // T4: K=1 passes pixels through with one cycle of latency
    for (int i = 0; i < 4; i++) begin
      push_b(20'(7 + i), i == 3);
      send_b(16'(7 + i));
      chk("t4_latency_valid", 32'(b_out_valid), 32'd1);
      chk("t4_latency_data",  32'(b_out_data),  32'(7 + i));
    end
    drain("t4_drain");

    // T6: back-to-back frames, second one offset by 1
    push_t1(0);
    push_t1(1);
    frame_a(0);
    frame_a(1);
    drain("t6_drain");

    // T5: reset mid-frame while a sum is held (11 pixels reach the first window)
    a_out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_a(16'(i));
    chk("t5_pre_valid", 32'(a_out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(a_out_valid), 32'd0);
    chk("t5_rst_data",  32'(a_out_data),  32'd0);
    chk("t5_rst_last",  32'(a_out_last),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_out_ready = 1'b1;
    push_t1(0);
    frame_a(0);
    drain("t5_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
